// File: rtl/clk_div_bank.sv
// clk_div_bank: a bank of runtime-programmable clock-enable / divided-clock
// generators, all in the clkin domain. Each channel counts 0..div-1 and
// decodes its registered outputs from the next-state count. New settings
// wait in a pending register and are only applied on a period boundary
// (the natural wrap or a sync), so an output never shows a partial period.
module clk_div_bank #(
  parameter int CHANNELS    = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 82,
  parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clkin,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic [DIV_W-1:0]    cfg_high,
  input  logic                sync,
  output logic [CHANNELS-1:0] clk_en,
  output logic [CHANNELS-1:0] clk_div,
  output logic [CHANNELS-1:0] pend,
  output logic                cfg_err,
  output logic                lock
);

  localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] RST_HIGH = DIV_W'(DEFAULT_DIV / 2);
  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);

  logic                cfg_ok;
  logic [DIV_W-1:0]    cfg_high_eff;
  logic [CHANNELS-1:0] en_next;
  logic [CHANNELS-1:0] seen;

  // Qualify the write and clamp the high-time before it is stored as pending
  always_comb begin
    cfg_ok = (cfg_div >= DIV_W'(2)) && (32'(cfg_ch) < CHANNELS);
    if (cfg_high == '0)
      cfg_high_eff = cfg_div >> 1;
    else if (cfg_high >= cfg_div)
      cfg_high_eff = cfg_div - ONE;
    else
      cfg_high_eff = cfg_high;
  end

  // Rejected-write pulse, per-channel first-enable tracking and lock flag
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
      seen    <= '0;
      lock    <= 1'b0;
    end else begin
      cfg_err <= cfg_we & ~cfg_ok;
      seen    <= seen | en_next;
      lock    <= &seen;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DIV_W-1:0] cnt, div, high, pdiv, phigh;
    logic [DIV_W-1:0] cnt_n, div_n, high_n, pdiv_n, phigh_n;
    logic             pend_q, pend_n, en_q, div_q;
    logic             hit, wrap;

    // Next count and configuration; apply uses the pending value held before
    // this edge, so a write landing on a boundary waits one more period
    always_comb begin
      hit     = cfg_we && cfg_ok && (cfg_ch == CH_W'(i));
      wrap    = (cnt == div - ONE);
      cnt_n   = cnt + ONE;
      div_n   = div;
      high_n  = high;
      pdiv_n  = pdiv;
      phigh_n = phigh;
      pend_n  = pend_q;
      if (sync || wrap) begin
        cnt_n = '0;
        if (pend_q) begin
          div_n  = pdiv;
          high_n = phigh;
          pend_n = 1'b0;
        end
      end
      if (hit) begin
        pdiv_n  = cfg_div;
        phigh_n = cfg_high_eff;
        pend_n  = 1'b1;
      end
    end

    assign en_next[i] = (cnt_n == '0);

    // Channel state and registered outputs decoded from next-state values
    always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        div    <= RST_DIV;
        high   <= RST_HIGH;
        pdiv   <= RST_DIV;
        phigh  <= RST_HIGH;
        pend_q <= 1'b0;
        en_q   <= 1'b0;
        div_q  <= 1'b0;
      end else begin
        cnt    <= cnt_n;
        div    <= div_n;
        high   <= high_n;
        pdiv   <= pdiv_n;
        phigh  <= phigh_n;
        pend_q <= pend_n;
        en_q   <= en_next[i];
        div_q  <= (cnt_n < high_n);
      end
    end

    assign clk_en[i]  = en_q;
    assign clk_div[i] = div_q;
    assign pend[i]    = pend_q;
  end

endmodule
